// File: rtl/tube_driver.sv
// rtl/tube_driver.sv - memory-mapped 8-digit seven-segment scan driver
module tube_driver #(
    parameter int          SCAN_DIV  = 50000,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f38
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic [7:0]  digit_sel_n,
    output logic [7:0]  seg_n
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [31:0]   data_reg;
    logic [16:0]   ctrl_reg;
    logic [PW-1:0] prescale;
    logic [2:0]    idx;
    logic [31:0]   offset;
    logic          cs;
    logic          reg_sel;
    logic [3:0]    nibble;

    assign offset  = Addr - BASE_ADDR;
    assign cs      = (Addr >= BASE_ADDR) && (offset < 32'd8);
    assign reg_sel = offset[2];
    assign nibble  = data_reg[4*idx +: 4];

    always_comb begin
        Dout = 32'h0;
        if (cs)
            Dout = reg_sel ? {15'h0, ctrl_reg} : data_reg;
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg    <= 32'h0;
            ctrl_reg    <= 17'h000FF;
            prescale    <= '0;
            idx         <= 3'd0;
            digit_sel_n <= 8'hFF;
            seg_n       <= 8'hFF;
        end else begin
            if (WE && cs) begin
                if (!reg_sel) begin
                    for (int i = 0; i < 4; i++)
                        if (BE[i])
                            data_reg[8*i +: 8] <= Din[8*i +: 8];
                end else begin
                    if (BE[0]) ctrl_reg[7:0]  <= Din[7:0];
                    if (BE[1]) ctrl_reg[15:8] <= Din[15:8];
                    if (BE[2]) ctrl_reg[16]   <= Din[16];
                end
            end

            // Scan runs regardless of blank/masks so every digit keeps a 1/8 duty slot.
            if (prescale == PW'(SCAN_DIV - 1)) begin
                prescale <= '0;
                idx      <= idx + 3'd1;
            end else begin
                prescale <= prescale + PW'(1);
            end

            if (ctrl_reg[16] || !ctrl_reg[idx]) begin
                digit_sel_n <= 8'hFF;
                seg_n       <= 8'hFF;
            end else begin
                digit_sel_n <= ~(8'd1 << idx);
                seg_n       <= {~ctrl_reg[8 + idx], ~hex7(nibble)};
            end
        end
    end
endmodule

// File: tb/tb_tube_driver.sv
// tb/tb_tube_driver.sv - randomized model-checked bench for tube_driver
module tb_tube_driver;
    localparam int          SD   = 4;
    localparam logic [31:0] BASE = 32'h0000_7f38;
    localparam logic [6:0]  HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [7:0]  digit_sel_n;
    logic [7:0]  seg_n;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_data;
    logic [31:0] m_ctrl;
    int          m_t;
    bit          m_valid = 0;
    logic [7:0]  e_sel;
    logic [7:0]  e_seg;

    tube_driver #(.SCAN_DIV(SD), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .BE(BE), .Din(Din),
        .Dout(Dout), .digit_sel_n(digit_sel_n), .seg_n(seg_n)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd7);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!in_win(a)) return 32'h0;
        return off[2] ? m_ctrl : m_data;
    endfunction

    // Reference: idx is simply elapsed-cycles / SCAN_DIV mod 8; outputs show the pre-edge state.
    initial begin
        int d;
        logic [3:0] nib;
        logic [31:0] off;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_data = 0; m_ctrl = 32'hFF; m_t = 0;
                e_sel = 8'hFF; e_seg = 8'hFF; m_valid = 1;
            end else if (m_valid) begin
                d = (m_t / SD) % 8;
                if (m_ctrl[16] || !m_ctrl[d]) begin
                    e_sel = 8'hFF; e_seg = 8'hFF;
                end else begin
                    nib = m_data[4*d +: 4];
                    e_sel = ~(8'd1 << d);
                    e_seg = {~m_ctrl[8+d], ~HEX[nib]};
                end
                if (WE && in_win(Addr)) begin
                    off = Addr - BASE;
                    for (int b = 0; b < 4; b++)
                        if (BE[b]) begin
                            if (off[2]) m_ctrl[8*b +: 8] = Din[8*b +: 8];
                            else        m_data[8*b +: 8] = Din[8*b +: 8];
                        end
                    m_ctrl = m_ctrl & 32'h0001_FFFF;
                end
                m_t++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (m_valid) begin
                chk("model_sel", {24'h0, digit_sel_n}, {24'h0, e_sel});
                chk("model_seg", {24'h0, seg_n}, {24'h0, e_seg});
                chk("model_dout", Dout, m_read(Addr));
            end
        end
    end

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        Addr = a; Din = d; BE = b; WE = 1;
        @(negedge clk);
        WE = 0; BE = 0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(name, Dout, exp);
    endtask

    task automatic wait_digit(input int k);
        logic [7:0] want;
        bit found;
        want = ~(8'd1 << k);
        found = 0;
        @(negedge clk);
        for (int i = 0; i < 64 && !found; i++) begin
            if (digit_sel_n === want) found = 1;
            else @(negedge clk);
        end
        if (!found) begin
            tests++; fails++;
            $display("FAIL wait_digit%0d: timeout, sel %h required %h", k, digit_sel_n, want);
        end
        #1;
    endtask

    initial begin
        int bad;
        reset = 1; WE = 0; BE = 0; Addr = BASE; Din = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        chk("dark_sel", {24'h0, digit_sel_n}, 32'hFF);
        chk("dark_seg", {24'h0, seg_n}, 32'hFF);
        @(negedge clk); #1;
        chk("first_sel", {24'h0, digit_sel_n}, 32'hFE);
        chk("first_seg", {24'h0, seg_n}, 32'hC0);
        repeat (4) @(negedge clk); #1;
        chk("slot1_sel", {24'h0, digit_sel_n}, 32'hFD);
        repeat (24) @(negedge clk); #1;
        chk("slot7_sel", {24'h0, digit_sel_n}, 32'h7F);
        repeat (4) @(negedge clk); #1;
        chk("wrap_sel", {24'h0, digit_sel_n}, 32'hFE);

        write(BASE, 32'h8765_4321, 4'hF);
        rd_chk("rd_data", BASE, 32'h8765_4321);
        wait_digit(0); chk("seg_d0", {24'h0, seg_n}, 32'hF9);
        wait_digit(3); chk("seg_d3", {24'h0, seg_n}, 32'h99);
        wait_digit(7); chk("seg_d7", {24'h0, seg_n}, 32'h80);

        write(BASE, 32'hFFFF_FFFF, 4'b0100);
        rd_chk("rd_be", BASE, 32'h87FF_4321);
        wait_digit(4); chk("seg_d4", {24'h0, seg_n}, 32'h8E);
        wait_digit(5); chk("seg_d5", {24'h0, seg_n}, 32'h8E);

        write(BASE + 4, 32'hFFFF_0301, 4'hF);
        rd_chk("rd_ctrl", BASE + 4, 32'h0001_0301);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk); #1;
            if (digit_sel_n !== 8'hFF || seg_n !== 8'hFF) bad++;
        end
        chk("blank_dark", bad, 0);

        write(BASE + 4, 32'h0000_0301, 4'hF);
        wait_digit(0); chk("seg_d0_dp", {24'h0, seg_n}, 32'h79);
        for (int i = 0; i < 8 && digit_sel_n === 8'hFE; i++) @(negedge clk);
        #1;
        chk("d1_masked_sel", {24'h0, digit_sel_n}, 32'hFF);
        chk("d1_masked_seg", {24'h0, seg_n}, 32'hFF);

        rd_chk("rd_above", 32'h0000_7f40, 32'h0);
        rd_chk("rd_below", 32'h0000_7f34, 32'h0);
        write(32'h0000_7f40, 32'h1234_5678, 4'hF);
        write(32'h0000_7f34, 32'h1234_5678, 4'hF);
        rd_chk("rd_data_kept", BASE, 32'h87FF_4321);
        rd_chk("rd_ctrl_kept", BASE + 4, 32'h0000_0301);

        for (int i = 0; i < 64 && ((m_t / SD) % 8) != 5; i++) @(negedge clk);
        chk("reach_idx5", (m_t / SD) % 8, 5);
        reset = 1;
        @(negedge clk);
        reset = 0;
        rd_chk("rst_data", BASE, 32'h0);
        rd_chk("rst_ctrl", BASE + 4, 32'hFF);
        chk("rst_sel", {24'h0, digit_sel_n}, 32'hFF);
        chk("rst_seg", {24'h0, seg_n}, 32'hFF);
        @(negedge clk); #1;
        chk("rst_first_sel", {24'h0, digit_sel_n}, 32'hFE);
        chk("rst_first_seg", {24'h0, seg_n}, 32'hC0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            WE    = ($urandom_range(0, 2) == 0);
            Addr  = 32'h0000_7f30 + 32'($urandom_range(0, 23));
            BE    = 4'($urandom);
            Din   = $urandom;
        end
        @(negedge clk);
        reset = 0; WE = 0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
